// File: rtl/iic_pkg.sv
// I2C register responder: shared state encoding
// and default device address.
package iic_pkg;

  localparam logic [6:0] IIC_DEV_ADDR = 7'h76;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RD_MACK,
    S_IGNORE
  } iic_state_e;

endpackage

// File: rtl/iic_sync_edge.sv
// Two-flop synchronizer plus history flop for
// one bus line, with rise/fall detection.
module iic_sync_edge (
  input  logic Clk,
  input  logic Reset_n,
  input  logic i_line,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_hist;

  // synchronize and keep one sample of history
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_hist <= 1'b1;
    end else begin
      r_s1   <= i_line;
      r_s2   <= r_s1;
      r_hist <= r_s2;
    end
  end

  assign o_lvl  = r_s2;
  assign o_rise = r_s2 & ~r_hist;
  assign o_fall = ~r_s2 & r_hist;

endmodule

// File: rtl/iic_responder.sv
// I2C slave with a pointer-addressed byte
// register file; writes are strobed out.
module iic_responder
  import iic_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = IIC_DEV_ADDR,
  parameter int         ADDR_W   = 6
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;

  iic_sync_edge u_scl (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .i_line  (scl_in),
    .o_lvl   (w_scl),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  iic_sync_edge u_sda (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .i_line  (sda_in),
    .o_lvl   (w_sda),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  assign w_start = w_sda_fall & w_scl;
  assign w_stop  = w_sda_rise & w_scl;

  iic_state_e        r_state, w_state;
  logic [3:0]        r_bit, w_bit;
  logic [7:0]        r_shift, w_shift;
  logic              r_rw, w_rw;
  logic [ADDR_W-1:0] r_ptr, w_ptr;
  logic              r_oe, w_oe;
  logic              r_busy, w_busy;
  logic              r_wr_stb;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic [7:0]        r_mem [DEPTH];
  logic              w_we;
  logic [7:0]        w_sin;
  logic [ADDR_W-1:0] w_ptr_inc;
  logic [7:0]        w_rd, w_rd_nx;

  assign w_sin     = {r_shift[6:0], w_sda};
  assign w_ptr_inc = r_ptr + 1'b1;
  assign w_rd      = r_mem[r_ptr];
  assign w_rd_nx   = r_mem[w_ptr_inc];

  // protocol state register, strobes and register file
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state   <= S_IDLE;
      r_bit     <= '0;
      r_shift   <= '0;
      r_rw      <= 1'b0;
      r_ptr     <= '0;
      r_oe      <= 1'b0;
      r_busy    <= 1'b0;
      r_wr_stb  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_state  <= w_state;
      r_bit    <= w_bit;
      r_shift  <= w_shift;
      r_rw     <= w_rw;
      r_ptr    <= w_ptr;
      r_oe     <= w_oe;
      r_busy   <= w_busy;
      r_wr_stb <= w_we;
      if (w_we) begin
        r_mem[r_ptr] <= w_sin;
        r_wr_addr    <= r_ptr;
        r_wr_data    <= w_sin;
      end
    end
  end

  // next state: bits in on SCL rise, SDA drive on SCL fall
  always_comb begin
    w_state = r_state;
    w_bit   = r_bit;
    w_shift = r_shift;
    w_rw    = r_rw;
    w_ptr   = r_ptr;
    w_oe    = r_oe;
    w_busy  = r_busy;
    w_we    = 1'b0;
    if (w_start) begin
      w_state = S_ADDR;
      w_bit   = '0;
      w_oe    = 1'b0;
    end else if (w_stop) begin
      w_state = S_IDLE;
      w_bit   = '0;
      w_oe    = 1'b0;
      w_busy  = 1'b0;
    end else begin
      case (r_state)
        S_ADDR, S_PTR, S_WDATA: begin
          if (w_scl_rise) begin
            w_shift = w_sin;
            w_bit   = r_bit + 4'd1;
            if (r_bit == 4'd7) begin
              if (r_state == S_ADDR) begin
                if (w_sin[7:1] == DEV_ADDR) begin
                  w_state = S_ADDR_ACK;
                  w_rw    = w_sin[0];
                  w_busy  = 1'b1;
                end else begin
                  w_state = S_IGNORE;
                  w_busy  = 1'b0;
                end
              end else if (r_state == S_PTR) begin
                w_ptr   = w_sin[ADDR_W-1:0];
                w_state = S_PTR_ACK;
              end else begin
                w_we    = 1'b1;
                w_ptr   = w_ptr_inc;
                w_state = S_WDATA_ACK;
              end
            end
          end
        end
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
          if (w_scl_fall) begin
            if (!r_oe) begin
              w_oe = 1'b1;
            end else begin
              w_oe  = 1'b0;
              w_bit = '0;
              if (r_state != S_ADDR_ACK) begin
                w_state = S_WDATA;
              end else if (r_rw) begin
                w_state = S_RDATA;
                w_shift = w_rd;
                w_oe    = ~w_rd[7];
              end else begin
                w_state = S_PTR;
              end
            end
          end
        end
        S_RDATA: begin
          if (w_scl_rise) begin
            w_bit = r_bit + 4'd1;
          end else if (w_scl_fall) begin
            if (r_bit == 4'd8) begin
              w_oe    = 1'b0;
              w_state = S_RD_MACK;
            end else begin
              w_oe = ~r_shift[3'd7 - r_bit[2:0]];
            end
          end
        end
        S_RD_MACK: begin
          if (w_scl_rise) begin
            w_ptr = w_ptr_inc;
            if (!w_sda) begin
              w_state = S_RDATA;
              w_bit   = '0;
              w_shift = w_rd_nx;
            end else begin
              w_state = S_IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe  = r_oe;
  assign busy    = r_busy;
  assign wr_stb  = r_wr_stb;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

endmodule

// File: tb/tb_iic_responder.sv
// Bench for iic_responder: bit-banged master,
// model register file and write scoreboard.
module tb_iic_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  wire        sda_line;
  logic       sda_oe;
  logic       wr_stb;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  assign sda_line = m_sda & ~sda_oe;

  iic_responder dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .scl_in  (m_scl),
    .sda_in  (sda_line),
    .sda_oe  (sda_oe),
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy)
  );

  always #20 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int qt = 20;
  logic oe_seen = 1'b0;
  logic [7:0] mdl_mem [64];
  logic [5:0] mdl_ptr = '0;
  logic [13:0] q_wr [$];
  logic [7:0]  q_rd [$];
  logic [7:0]  txq [$];
  logic prev_oe = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // write strobes are matched against the scoreboard
  always @(negedge clk) begin
    if (wr_stb) begin
      if (q_wr.size() == 0) begin
        chk("wr_extra", 1, 0);
      end else begin
        logic [13:0] e;
        e = q_wr.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e[13:8]));
        chk("wr_data", 32'(wr_data), 32'(e[7:0]));
      end
    end
  end

  // SDA drive must not move while SCL is high
  always @(negedge clk) begin
    if (rst_n && sda_oe != prev_oe)
      chk("oe_scl_hi", 32'(m_scl), 0);
    prev_oe <= sda_oe;
  end

  task automatic wq(input int n);
    repeat (n) begin
      @(posedge clk);
      if (sda_oe) oe_seen = 1'b1;
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < 64; i++) mdl_mem[i] = 8'h00;
    mdl_ptr = '0;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wq(qt);
    m_scl = 1'b1; wq(qt);
    m_sda = 1'b0; wq(qt);
    m_scl = 1'b0; wq(qt);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wq(qt);
    m_scl = 1'b1; wq(qt);
    m_sda = 1'b1; wq(qt);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;    wq(qt);
    m_scl = 1'b1; wq(2 * qt);
    m_scl = 1'b0; wq(qt);
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; wq(qt);
    m_scl = 1'b1; wq(qt);
    b = sda_line; wq(qt);
    m_scl = 1'b0; wq(qt);
  endtask

  task automatic send_byte(input logic [7:0] v,
                           input logic exp_ack,
                           input string tag);
    logic a;
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    recv_bit(a);
    chk(tag, 32'(a), 32'(exp_ack));
  endtask

  task automatic wr_txn(input logic [7:0] p,
                        input logic do_stop);
    i2c_start();
    send_byte(8'hEC, 1'b0, "addr_ack");
    chk("busy_wr", 32'(busy), 1);
    send_byte(p, 1'b0, "ptr_ack");
    mdl_ptr = p[5:0];
    for (int i = 0; i < txq.size(); i++) begin
      q_wr.push_back({mdl_ptr, txq[i]});
      mdl_mem[mdl_ptr] = txq[i];
      send_byte(txq[i], 1'b0, "data_ack");
      mdl_ptr = mdl_ptr + 6'd1;
    end
    if (do_stop) begin
      i2c_stop();
      wq(qt);
      chk("busy_stop", 32'(busy), 0);
    end
  endtask

  task automatic rd_txn(input int n);
    logic [7:0] got;
    i2c_start();
    send_byte(8'hED, 1'b0, "rd_addr_ack");
    chk("busy_rd", 32'(busy), 1);
    for (int i = 0; i < n; i++) begin
      q_rd.push_back(mdl_mem[mdl_ptr]);
      for (int k = 7; k >= 0; k--) recv_bit(got[k]);
      send_bit((i == n - 1) ? 1'b1 : 1'b0);
      chk("rd_data", 32'(got), 32'(q_rd.pop_front()));
      mdl_ptr = mdl_ptr + 6'd1;
    end
    i2c_stop();
    wq(qt);
    chk("busy_rd_stop", 32'(busy), 0);
  endtask

  initial begin
    mdl_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_oe", 32'(sda_oe), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_stb", 32'(wr_stb), 0);
    chk("rst_waddr", 32'(wr_addr), 0);
    chk("rst_wdata", 32'(wr_data), 0);
    rst_n = 1'b1;
    wq(10);

    // single write at ~100 kHz SCL
    qt = 62;
    txq = {8'hC0};
    wr_txn(8'h49, 1'b1);
    qt = 20;

    // pointer-only write, then one-byte read
    txq = {};
    wr_txn(8'h09, 1'b1);
    rd_txn(1);

    // foreign address is ignored
    oe_seen = 1'b0;
    i2c_start();
    send_byte(8'hEA, 1'b1, "nomatch_nack");
    chk("nomatch_busy", 32'(busy), 0);
    send_byte(8'h12, 1'b1, "nomatch_data");
    i2c_stop();
    wq(qt);
    chk("nomatch_oe", 32'(oe_seen), 0);

    // pointer wrap on write
    txq = {8'h11, 8'h22};
    wr_txn(8'h3F, 1'b1);
    txq = {};
    wr_txn(8'h3F, 1'b1);
    rd_txn(2);

    // reset in the middle of a data byte
    i2c_start();
    send_byte(8'hEC, 1'b0, "rst_addr_ack");
    send_byte(8'h05, 1'b0, "rst_ptr_ack");
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rst_n = 1'b0;
    wq(2);
    rst_n = 1'b1;
    mdl_reset();
    @(negedge clk);
    chk("rst_mid_oe", 32'(sda_oe), 0);
    oe_seen = 1'b0;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    send_byte(8'hFF, 1'b1, "rst_after_nack");
    chk("rst_mid_seen", 32'(oe_seen), 0);
    i2c_stop();
    wq(qt);
    txq = {8'hA5};
    wr_txn(8'h05, 1'b1);
    txq = {};
    wr_txn(8'h05, 1'b1);
    rd_txn(1);

    // repeated START into a 3-byte burst read
    txq = {8'h31, 8'h32, 8'h33, 8'h34};
    wr_txn(8'h10, 1'b1);
    txq = {};
    wr_txn(8'h10, 1'b0);
    rd_txn(3);
    rd_txn(1);

    wq(20);
    chk("wr_pending", 32'(q_wr.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/iic_responder.md
IIC_RESPONDER -- requirements
Module: iic_responder

Interface
REQ-001 The module SHALL have parameter DEV_ADDR, default 7'h76, the 7-bit I2C device address it answers to.
REQ-002 The module SHALL have parameter ADDR_W, default 6, the register-file address width (depth 2^ADDR_W bytes).
REQ-003 Port Clk, input, 1, the single system clock (25 MHz pixel clock domain); all logic is rising-edge.
REQ-004 Port Reset_n, input, 1, reset; reset is synchronous and active-low.
REQ-005 Port scl_in, input, 1, raw SCL line level (asynchronous).
REQ-006 Port sda_in, input, 1, raw SDA line level (asynchronous).
REQ-007 Port sda_oe, output, 1, 1 = pull SDA low; 0 = release (top level converts to tri-state).
REQ-008 Port wr_stb, output, 1, one-Clk pulse per register byte written.
REQ-009 Port wr_addr, output, ADDR_W, register address of the write; valid with wr_stb.
REQ-010 Port wr_data, output, 8, byte written; valid with wr_stb.
REQ-011 Port busy, output, 1, high from accepted START with matching address until STOP.

Function
REQ-012 scl_in/sda_in SHALL pass a 2-flop synchronizer plus one history flop; edges are detected on synchronized values (3-Clk input latency).
REQ-013 START = synchronized SDA falling while SCL high; STOP = SDA rising while SCL high; both are recognized in every state, including mid-byte.
REQ-014 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK, IGNORE.
REQ-015 START from any state -> ADDR, bit counter cleared, sda_oe released; repeated START is treated identically.
REQ-016 STOP from any state -> IDLE, sda_oe = 0, busy = 0.
REQ-017 SDA is sampled on SCL rising edge, MSB first; sda_oe changes only on SCL falling edge.
REQ-018 After 8 address bits: address match -> ADDR_ACK (sda_oe = 1 from next SCL fall to following SCL fall); mismatch -> IGNORE, no ACK, until START/STOP.
REQ-019 R/W = 0 -> PTR: next byte loads pointer (low ADDR_W bits), ACKed, -> WDATA.
REQ-020 WDATA: each byte is written to reg[pointer], wr_stb pulses on the Clk after the 8th SCL rise, ACKed, pointer increments modulo 2^ADDR_W.
REQ-021 R/W = 1 -> RDATA: reg[pointer] is driven from the SCL fall ending ADDR_ACK, sda_oe = ~bit; after 8 bits sda_oe released, -> RD_MACK.
REQ-022 RD_MACK: master ACK (SDA low at SCL rise) -> pointer+1 (wrap), next byte; master NACK -> IGNORE.
REQ-023 Pointer persists across transactions; a read after a write-pointer-only transaction starts at that pointer.
REQ-024 sda_oe SHALL never change while synchronized SCL is high.
REQ-025 busy rises on the Clk the address ACK is decided and falls on STOP or on address mismatch.

Reset
REQ-026 Reset_n low at a Clk edge: state IDLE, sda_oe 0, wr_stb 0, wr_addr 0, wr_data 0, busy 0, pointer 0, bit counter 0, all register bytes 8'h00, synchronizers 1 (idle bus).
REQ-027 Reset asserted mid-transaction SHALL abort it; after release the block waits for a fresh START, ignoring the remainder of the in-flight byte.

Structure
REQ-028 Package iic_pkg SHALL hold the state encoding and default DEV_ADDR constant; dvi_ifc testbenches reuse it.
REQ-029 One sub-module iic_sync_edge SHALL implement the per-line synchronizer and rise/fall detection, instantiated twice.
REQ-030 Register file SHALL be a flop array (2^ADDR_W x 8) with reset; no vendor RAM primitive.

Verification
REQ-031 Write S,0xEC,0x49,0xC0,P at 100 kHz SCL -> three ACKs, one wr_stb with wr_addr 0x09 (0x49 mod 64), wr_data 0xC0.
REQ-032 Write S,0xEC,0x09,P then S,0xED, read 1 byte, NACK, P -> SDA returns 0xC0; busy low after STOP.
REQ-033 Address 0xEA (7'h75) -> no ACK on 9th clock, sda_oe 0 throughout, busy 0, no wr_stb.
REQ-034 Write S,0xEC,0x3F,0x11,0x22,P -> reg[0x3F]=0x11, reg[0x00]=0x22 (wrap), two wr_stb pulses.
REQ-035 Reset_n low for 2 Clk during 4th data bit of a write -> no wr_stb, sda_oe 0; following complete transaction ACKs normally.
REQ-036 Repeated START after pointer byte 0x10 with 0xED, burst read 3 bytes (ACK,ACK,NACK) -> bytes from 0x10,0x11,0x12; pointer ends 0x13.
